// File: rtl/dpe_if.sv
// dpe_if: AXI-Stream-like packet channel between the DPE multiplexer and demultiplexer.
//   tvalid/tready : beat handshake
//   tdata         : TDATA_WIDTH payload
//   tkeep         : TDATA_WIDTH/8 byte enables
//   tlast         : last beat of packet
//   tuser         : TUSER_WIDTH one-hot destination mask (first beat only)
// master drives the payload, slave drives tready.
interface dpe_if #(
    parameter int unsigned TDATA_WIDTH = 128,
    parameter int unsigned TUSER_WIDTH = 5
);
    localparam int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/dpe_demultiplexer.sv
// dpe_demultiplexer: routes packets from one muxed stream to one of five outputs.
// The destination is the one-hot tuser of the first beat; zero or multi-hot
// destinations are sunk. One output register slice gives 1-cycle latency at
// full throughput. pause halts acceptance at the next packet boundary.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pause       : request halt at packet boundary
//   paused      : halted and slice empty
//   inp         : dpe_if slave, muxed input stream
//   out0..out4  : dpe_if master, per-destination streams
//   drop_cnt    : saturating dropped-packet counter (only with DPE_DEMUX_DROP_CNT_EN)
// Optional feature macro: DPE_DEMUX_DROP_CNT_EN
module dpe_demultiplexer #(
    parameter int unsigned TDATA_WIDTH = 128,
    parameter int unsigned TUSER_WIDTH = 5
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   pause,
    output logic   paused,
    dpe_if.slave   inp,
    dpe_if.master  out0,
    dpe_if.master  out1,
    dpe_if.master  out2,
    dpe_if.master  out3,
    dpe_if.master  out4
`ifdef DPE_DEMUX_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    localparam int unsigned NUM_PORTS = 5;
    localparam int unsigned PORT_W    = 3;
    localparam int unsigned KEEP_W    = TDATA_WIDTH / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FWD  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;
    localparam logic [1:0] HALT = 2'd3;

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic                   ready_en;

    logic                   slice_valid;
    logic [TDATA_WIDTH-1:0] slice_data;
    logic [KEEP_W-1:0]      slice_keep;
    logic                   slice_last;
    logic [TUSER_WIDTH-1:0] slice_user;
    logic [PORT_W-1:0]      slice_port;
    logic [PORT_W-1:0]      fwd_port;

    logic [NUM_PORTS-1:0]   out_ready;
    logic                   sel_ready;
    logic                   drain;
    logic                   can_take;
    logic                   first_valid;
    logic [PORT_W-1:0]      first_port;
    logic                   load;
    logic [PORT_W-1:0]      load_port;
    logic                   tready_c;
    logic                   slice_valid_next;
`ifdef DPE_DEMUX_DROP_CNT_EN
    logic                   count_drop;
`endif

    assign out_ready = {out4.tready, out3.tready, out2.tready, out1.tready, out0.tready};
    assign sel_ready = out_ready[slice_port];
    assign drain     = slice_valid & sel_ready;
    // ready_en keeps tready low until the first edge after reset release
    assign can_take  = ready_en & (~slice_valid | sel_ready);

    // Destination decode of the current first-beat candidate
    always_comb begin
        first_port  = '0;
        first_valid = $onehot(inp.tuser);
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (inp.tuser[i]) begin
                first_port = PORT_W'(i);
            end
        end
    end

    // Next-state, handshake and slice-load control
    always_comb begin
        state_next = state;
        tready_c   = 1'b0;
        load       = 1'b0;
        load_port  = fwd_port;
`ifdef DPE_DEMUX_DROP_CNT_EN
        count_drop = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pause) begin
                    state_next = HALT;
                end else begin
                    tready_c = can_take;
                    if (inp.tvalid && can_take) begin
                        if (first_valid) begin
                            load      = 1'b1;
                            load_port = first_port;
                            if (!inp.tlast) begin
                                state_next = FWD;
                            end
                        end else begin
`ifdef DPE_DEMUX_DROP_CNT_EN
                            count_drop = 1'b1;
`endif
                            if (!inp.tlast) begin
                                state_next = DROP;
                            end
                        end
                    end
                end
            end
            FWD: begin
                tready_c = can_take;
                if (inp.tvalid && can_take) begin
                    load = 1'b1;
                    if (inp.tlast) begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                tready_c = ready_en;
                if (inp.tvalid && ready_en && inp.tlast) begin
                    state_next = IDLE;
                end
            end
            HALT: begin
                if (!pause) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign slice_valid_next = load | (slice_valid & ~drain);
    assign inp.tready       = tready_c;

    // FSM state, reset-release gate and paused flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
            paused   <= 1'b0;
            fwd_port <= '0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
            paused   <= (state_next == HALT) && !slice_valid_next;
            if (load) begin
                fwd_port <= load_port;
            end
        end
    end

    // Output register slice; load only happens when the slice is empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_valid <= 1'b0;
            slice_data  <= '0;
            slice_keep  <= '0;
            slice_last  <= 1'b0;
            slice_user  <= '0;
            slice_port  <= '0;
        end else begin
            slice_valid <= slice_valid_next;
            if (load) begin
                slice_data <= inp.tdata;
                slice_keep <= inp.tkeep;
                slice_last <= inp.tlast;
                slice_user <= inp.tuser;
                slice_port <= load_port;
            end
        end
    end

`ifdef DPE_DEMUX_DROP_CNT_EN
    // Saturating count of packets sunk as invalid destinations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
        end else if (count_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    assign out0.tvalid = slice_valid && (slice_port == PORT_W'(0));
    assign out1.tvalid = slice_valid && (slice_port == PORT_W'(1));
    assign out2.tvalid = slice_valid && (slice_port == PORT_W'(2));
    assign out3.tvalid = slice_valid && (slice_port == PORT_W'(3));
    assign out4.tvalid = slice_valid && (slice_port == PORT_W'(4));

    assign out0.tdata = slice_data;
    assign out1.tdata = slice_data;
    assign out2.tdata = slice_data;
    assign out3.tdata = slice_data;
    assign out4.tdata = slice_data;

    assign out0.tkeep = slice_keep;
    assign out1.tkeep = slice_keep;
    assign out2.tkeep = slice_keep;
    assign out3.tkeep = slice_keep;
    assign out4.tkeep = slice_keep;

    assign out0.tlast = slice_last;
    assign out1.tlast = slice_last;
    assign out2.tlast = slice_last;
    assign out3.tlast = slice_last;
    assign out4.tlast = slice_last;

    assign out0.tuser = slice_user;
    assign out1.tuser = slice_user;
    assign out2.tuser = slice_user;
    assign out3.tuser = slice_user;
    assign out4.tuser = slice_user;

endmodule

// File: tb/tb_dpe_demultiplexer.sv
// tb_dpe_demultiplexer: directed self-checking bench for dpe_demultiplexer.
// A negedge monitor compares every delivered beat against an ordered queue of
// hand-written expectations (port mask + data/keep/last) and checks hold stability.
module tb_dpe_demultiplexer;

    localparam int unsigned DW = 128;
    localparam int unsigned UW = 5;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned BW = DW + KW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pause = 1'b0;
    logic paused;

    always #5 clk = ~clk;

    dpe_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) inp_if ();
    dpe_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o0 ();
    dpe_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o1 ();
    dpe_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o2 ();
    dpe_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o3 ();
    dpe_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o4 ();

`ifdef DPE_DEMUX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    dpe_demultiplexer #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pause  (pause),
        .paused (paused),
        .inp    (inp_if),
        .out0   (o0),
        .out1   (o1),
        .out2   (o2),
        .out3   (o3),
        .out4   (o4)
`ifdef DPE_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    logic [4:0]    ordy = 5'h1F;
    logic [4:0]    ov;
    logic [BW-1:0] obeat [5];
    logic          toggle_en = 1'b0;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic [BW+4:0] expq [$];

    assign o0.tready = ordy[0];
    assign o1.tready = ordy[1];
    assign o2.tready = ordy[2];
    assign o3.tready = ordy[3];
    assign o4.tready = ordy[4];
    assign ov = {o4.tvalid, o3.tvalid, o2.tvalid, o1.tvalid, o0.tvalid};
    assign obeat[0] = {o0.tdata, o0.tkeep, o0.tlast};
    assign obeat[1] = {o1.tdata, o1.tkeep, o1.tlast};
    assign obeat[2] = {o2.tdata, o2.tkeep, o2.tlast};
    assign obeat[3] = {o3.tdata, o3.tkeep, o3.tlast};
    assign obeat[4] = {o4.tdata, o4.tkeep, o4.tlast};

    always @(posedge clk) cyc++;

    // Background back-pressure on out1
    always @(posedge clk) begin
        #1;
        if (toggle_en) ordy[1] = ~ordy[1];
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Delivered-beat monitor
    logic          prev_stall = 1'b0;
    logic [4:0]    prev_ov;
    logic [BW-1:0] prev_beat;
    always @(negedge clk) begin
        logic [BW-1:0] cur;
        logic [BW+4:0] e;
        cur = '0;
        if (rst_n && (ov != 5'd0)) begin
            for (int i = 0; i < 5; i++) if (ov[i]) cur = obeat[i];
            if (prev_stall) check("hold_stable", {ov, cur}, {prev_ov, prev_beat});
            if (expq.size() == 0) begin
                check("spurious_valid", ov, 5'd0);
            end else if ((ov & ordy) != 5'd0) begin
                e = expq.pop_front();
                check("route", ov, e[BW+4:BW]);
                check("beat", cur, e[BW-1:0]);
            end
            prev_stall = ((ov & ordy) == 5'd0);
            prev_ov    = ov;
            prev_beat  = cur;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic expect_beat(input logic [4:0] port, input logic [DW-1:0] d,
                               input logic [KW-1:0] k, input logic l);
        expq.push_back({port, d, k, l});
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic [UW-1:0] u, input logic l);
        int   n;
        logic r;
        n = 0;
        inp_if.tvalid = 1'b1;
        inp_if.tdata  = d;
        inp_if.tkeep  = k;
        inp_if.tuser  = u;
        inp_if.tlast  = l;
        do begin
            @(negedge clk);
            r = inp_if.tready;
            @(posedge clk);
            n++;
        end while (!r && n < 100);
        check("accept", r, 1'b1);
        #1;
        inp_if.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [UW-1:0] u_first, input logic [UW-1:0] u_rest,
                            input logic [DW-1:0] base, input int n, input logic [4:0] exp_port);
        for (int i = 0; i < n; i++) begin
            if (exp_port != 5'd0) expect_beat(exp_port, base + DW'(i), '1, (i == n - 1));
            send(base + DW'(i), '1, (i == 0) ? u_first : u_rest, (i == n - 1));
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check(tag, expq.size(), 0);
    endtask

    initial begin
        int c0;
        inp_if.tvalid = 1'b0;
        inp_if.tdata  = '0;
        inp_if.tkeep  = '0;
        inp_if.tlast  = 1'b0;
        inp_if.tuser  = '0;

        // Reset state and tready release timing
        #1;
        check("rst_valid", ov, 5'd0);
        check("rst_tready", inp_if.tready, 1'b0);
        check("rst_paused", paused, 1'b0);
`ifdef DPE_DEMUX_DROP_CNT_EN
        check("rst_drop_cnt", drop_cnt, 16'd0);
`endif
        #21 rst_n = 1'b1;
        #1;
        check("tready_before_edge", inp_if.tready, 1'b0);
        @(posedge clk);
        #1;
        check("tready_after_edge", inp_if.tready, 1'b1);

        // 4-beat packet to port 2, third beat with empty tkeep
        expect_beat(5'b00100, DW'(8'h15), '1, 1'b0);
        expect_beat(5'b00100, DW'(8'h16), '1, 1'b0);
        expect_beat(5'b00100, DW'(8'h17), '0, 1'b0);
        expect_beat(5'b00100, DW'(8'h18), '1, 1'b1);
        send(DW'(8'h15), '1, 5'b00100, 1'b0);
        check("latency_one", ov, 5'b00100);
        send(DW'(8'h16), '1, 5'b00000, 1'b0);
        send(DW'(8'h17), '0, 5'b00011, 1'b0);
        send(DW'(8'h18), '1, 5'b00000, 1'b1);
        drain("pkt_port2_done");

        // Invalid-destination packets are sunk
        send_pkt(5'b00000, 5'b00001, DW'(8'h40), 3, 5'd0);
        send_pkt(5'b00001, 5'b00000, DW'(8'h50), 2, 5'b00001);
        drain("drop_then_port0");
`ifdef DPE_DEMUX_DROP_CNT_EN
        check("drop_cnt_1", drop_cnt, 16'd1);
`endif
        send_pkt(5'b00011, 5'b00011, DW'(8'h60), 1, 5'd0);
        send_pkt(5'b00100, 5'b00100, DW'(8'h61), 1, 5'b00100);
        drain("multihot_single");
`ifdef DPE_DEMUX_DROP_CNT_EN
        check("drop_cnt_2", drop_cnt, 16'd2);
`endif

        // Back-pressure toggling on out1
        ordy[1] = 1'b0;
        toggle_en = 1'b1;
        send_pkt(5'b00010, 5'b00000, DW'(8'h70), 6, 5'b00010);
        drain("toggle_port1");
        toggle_en = 1'b0;
        @(posedge clk);
        #2 ordy = 5'h1F;

        // Pause mid-packet: packet completes, then halt
        for (int i = 0; i < 5; i++) expect_beat(5'b00010, DW'(8'h80 + i), '1, (i == 4));
        send(DW'(8'h80), '1, 5'b00010, 1'b0);
        send(DW'(8'h81), '1, 5'b00000, 1'b0);
        pause = 1'b1;
        send(DW'(8'h82), '1, 5'b00000, 1'b0);
        send(DW'(8'h83), '1, 5'b00000, 1'b0);
        send(DW'(8'h84), '1, 5'b00000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("halt_tready", inp_if.tready, 1'b0);
        check("halt_paused", paused, 1'b1);
        check("halt_queue", expq.size(), 0);
        inp_if.tvalid = 1'b1;
        inp_if.tdata  = DW'(8'hA0);
        inp_if.tuser  = 5'b00001;
        inp_if.tlast  = 1'b1;
        inp_if.tkeep  = '1;
        @(negedge clk);
        check("halt_blocks", inp_if.tready, 1'b0);
        @(posedge clk);
        #1 pause = 1'b0;
        @(posedge clk);
        #1;
        check("unpause", paused, 1'b0);
        expect_beat(5'b00001, DW'(8'hA0), '1, 1'b1);
        send(DW'(8'hA0), '1, 5'b00001, 1'b1);
        drain("resume_port0");

        // Reset mid-packet
        expect_beat(5'b01000, DW'(8'h30), '1, 1'b0);
        expect_beat(5'b01000, DW'(8'h31), '1, 1'b0);
        send(DW'(8'h30), '1, 5'b01000, 1'b0);
        send(DW'(8'h31), '1, 5'b00000, 1'b0);
        inp_if.tvalid = 1'b1;
        inp_if.tdata  = DW'(8'h32);
        inp_if.tlast  = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", ov, 5'd0);
        check("midrst_tready", inp_if.tready, 1'b0);
        check("midrst_queue", expq.size(), 0);
        inp_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(5'b10000, 5'b00000, DW'(8'h90), 3, 5'b10000);
        drain("post_reset_port4");

        // Back-to-back single-beat packets, one per cycle
        for (int i = 0; i < 5; i++) expect_beat(5'(1 << i), DW'(8'hC0 + i), '1, 1'b1);
        c0 = cyc;
        for (int i = 0; i < 5; i++) send(DW'(8'hC0 + i), '1, 5'(1 << i), 1'b1);
        check("b2b_cycles", cyc - c0, 5);
        drain("b2b_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
